// File: rtl/gf_digit_collector.sv
// Output-end deserializer for the digit-serial GF(2^m) multiplier: packs MSB-first digits into M-bit words.
// Optional macro WORD_PARITY_EN adds an out_parity port carrying ^out_word.
module gf_digit_collector #(
    parameter int M = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         in_sop,
    input  logic [D-1:0] in_digit,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_word,
`ifdef WORD_PARITY_EN
    output logic         out_parity,
`endif
    output logic         sop_err
);

    localparam int N   = M / D;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    // Shift register keeps the first N-1 digits; a dummy digit-wide register when N==1.
    localparam int SHW = (N > 1) ? (M - D) : D;

    logic [CW-1:0]  r_cnt;
    logic [SHW-1:0] r_sh;
    logic [M-1:0]   r_word;
    logic           r_valid;
    logic           r_err;
    logic           w_last;
    logic           w_in_ready;
    logic           w_accept;
    logic           w_drain;
    logic [M-1:0]   w_word_next;

    assign w_last      = (r_cnt == CW'(N - 1));
    assign w_in_ready  = !(w_last && r_valid && !out_ready);
    assign w_accept    = in_valid && w_in_ready;
    assign w_drain     = r_valid && out_ready;
    assign w_word_next = M'({r_sh, in_digit});

`ifdef WORD_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_parity <= 1'b0;
        end else if (w_accept && (N == 1 ? in_sop : (!in_sop && w_last && r_cnt != '0))) begin
            r_parity <= ^w_word_next;
        end
    end

    assign out_parity = r_parity;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_sh    <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_drain) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                if (in_sop) begin
                    if (N == 1) begin
                        r_word  <= w_word_next;
                        r_valid <= 1'b1;
                    end else begin
                        // A start-of-word mid-frame restarts assembly with this digit.
                        if (r_cnt != '0) begin
                            r_err <= 1'b1;
                        end
                        r_sh  <= SHW'(in_digit);
                        r_cnt <= CW'(1);
                    end
                end else if (r_cnt == '0) begin
                    r_err <= 1'b1;
                end else if (w_last) begin
                    r_word  <= w_word_next;
                    r_valid <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_sh  <= SHW'({r_sh, in_digit});
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out_word  = r_word;
    assign sop_err   = r_err;

endmodule

// File: tb/tb_gf_digit_collector.sv
// Bench for gf_digit_collector (M=16, D=4): directed framing/backpressure/reset steps plus random traffic
// compared cycle by cycle against a digit-list reference model.
module tb_gf_digit_collector;

    localparam int M = 16;
    localparam int D = 4;
    localparam int N = M / D;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_sop = 1'b0;
    logic [D-1:0] in_digit = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [M-1:0] out_word;
    logic         sop_err;
`ifdef WORD_PARITY_EN
    logic         out_parity;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model: digits of the word in progress, plus the output buffer.
    int unsigned  m_pend[$];
    bit           m_ov = 1'b0;
    logic [M-1:0] m_ow = '0;
    bit           m_err = 1'b0;

    gf_digit_collector #(.M(M), .D(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_digit  (in_digit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
`ifdef WORD_PARITY_EN
        .out_parity(out_parity),
`endif
        .sop_err   (sop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready(input bit ordy);
        return !(m_pend.size() == N - 1 && m_ov && !ordy);
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_ov});
        chk({tag, ".out_word"}, {16'd0, out_word}, {16'd0, m_ow});
        chk({tag, ".sop_err"}, {31'd0, sop_err}, {31'd0, m_err});
`ifdef WORD_PARITY_EN
        chk({tag, ".out_parity"}, {31'd0, out_parity}, {31'd0, ^m_ow});
`endif
    endtask

    task automatic step(input string tag, input bit v, input bit s, input logic [D-1:0] d, input bit ordy);
        bit acc;
        bit exp_rdy;
        int unsigned w;
        @(negedge clk);
        in_valid  = v;
        in_sop    = s;
        in_digit  = d;
        out_ready = ordy;
        #1;
        exp_rdy = model_ready(ordy);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
        acc = v && exp_rdy;
        @(posedge clk);
        m_err = 1'b0;
        if (m_ov && ordy) m_ov = 1'b0;
        if (acc) begin
            if (s) begin
                if (m_pend.size() != 0) m_err = 1'b1;
                m_pend.delete();
                m_pend.push_back(d);
            end else if (m_pend.size() == 0) begin
                m_err = 1'b1;
            end else begin
                m_pend.push_back(d);
            end
            if (m_pend.size() == N) begin
                w = 0;
                foreach (m_pend[i]) w = w * 16 + m_pend[i];
                m_ow = w[M-1:0];
                m_ov = 1'b1;
                m_pend.delete();
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic send_word(input string tag, input logic [M-1:0] w, input bit ordy);
        for (int i = 0; i < N; i++)
            step(tag, 1'b1, i == 0, w[M-1-4*i -: 4], ordy);
    endtask

    initial begin
        bit rv;
        bit rs;
        bit ro;
        #2;
        check_outputs("reset");
        chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;

        send_word("basic", 16'hABCD, 1'b1);
        chk("basic.word", {16'd0, out_word}, 32'hABCD);
        chk("basic.valid", {31'd0, out_valid}, 32'd1);
        step("idle", 1'b0, 1'b0, 4'h0, 1'b1);

        send_word("b2b1", 16'h1234, 1'b1);
        chk("b2b.first", {16'd0, out_word}, 32'h1234);
        send_word("b2b2", 16'h5678, 1'b1);
        chk("b2b.second", {16'd0, out_word}, 32'h5678);
        step("idle", 1'b0, 1'b0, 4'h0, 1'b1);

        send_word("bp1", 16'h1234, 1'b0);
        step("bp2", 1'b1, 1'b1, 4'h5, 1'b0);
        step("bp2", 1'b1, 1'b0, 4'h6, 1'b0);
        step("bp2", 1'b1, 1'b0, 4'h7, 1'b0);
        step("bp_stall", 1'b1, 1'b0, 4'h8, 1'b0);
        chk("bp.stall_ready", {31'd0, in_ready}, 32'd0);
        chk("bp.hold_word", {16'd0, out_word}, 32'h1234);
        step("bp_stall", 1'b1, 1'b0, 4'h8, 1'b0);
        step("bp_release", 1'b1, 1'b0, 4'h8, 1'b1);
        chk("bp.release_word", {16'd0, out_word}, 32'h5678);
        chk("bp.release_valid", {31'd0, out_valid}, 32'd1);
        step("idle", 1'b0, 1'b0, 4'h0, 1'b1);

        step("ferr_idle", 1'b1, 1'b0, 4'h9, 1'b1);
        chk("ferr.idle_pulse", {31'd0, sop_err}, 32'd1);
        step("ferr", 1'b1, 1'b1, 4'hA, 1'b1);
        chk("ferr.pulse_clears", {31'd0, sop_err}, 32'd0);
        step("ferr", 1'b1, 1'b0, 4'hB, 1'b1);
        step("ferr_resop", 1'b1, 1'b1, 4'hC, 1'b1);
        chk("ferr.resop_pulse", {31'd0, sop_err}, 32'd1);
        step("ferr", 1'b1, 1'b0, 4'hD, 1'b1);
        step("ferr", 1'b1, 1'b0, 4'hE, 1'b1);
        step("ferr", 1'b1, 1'b0, 4'hF, 1'b1);
        chk("ferr.word", {16'd0, out_word}, 32'hCDEF);

        send_word("prst", 16'h0001, 1'b0);
        step("prst", 1'b1, 1'b1, 4'h1, 1'b0);
        step("prst", 1'b1, 1'b0, 4'h2, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        m_pend.delete();
        m_ov = 1'b0;
        m_ow = '0;
        m_err = 1'b0;
        check_outputs("rst_mid");
        chk("rst_mid.word", {16'd0, out_word}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        send_word("post_rst", 16'h4321, 1'b1);
        chk("post_rst.word", {16'd0, out_word}, 32'h4321);

        for (int i = 0; i < 400; i++) begin
            rv = ($urandom % 4) != 0;
            rs = (m_pend.size() == 0) ? (($urandom % 8) != 0) : (($urandom % 10) == 0);
            ro = ($urandom % 3) != 0;
            step("rand", rv, rs, 4'($urandom), ro);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
